// File: rtl/pixel_writer.sv
// pixel_writer: takes shaded pixels (row, col, colour) from a valid/ready
// stream and writes each one byte by byte, little-endian, into the frame
// buffer through a byte-wide Avalon-MM master. It counts completed pixels
// and pulses frame_done when the last pixel of a frame has been written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a pixel, or applying a start (base/count update)
// S_WRITE | streaming the latched pixel's bytes out on m1
//
// PIXEL_BITS must be 8, 16 or 32.
module pixel_writer #(
  parameter  int TOTAL_ROWS = 192,
  parameter  int TOTAL_COLS = 256,
  parameter  int PIXEL_BITS = 16,
  localparam int RW = $clog2(TOTAL_ROWS),
  localparam int CW = $clog2(TOTAL_COLS),
  localparam int NW = $clog2(TOTAL_ROWS * TOTAL_COLS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           pixel_buffer,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RW-1:0]         in_row,
  input  logic [CW-1:0]         in_col,
  input  logic [PIXEL_BITS-1:0] in_color,
  output logic [31:0]           m1_address,
  output logic [7:0]            m1_writedata,
  output logic                  m1_write,
  input  logic                  m1_waitrequest,
  output logic                  busy,
  output logic                  frame_done,
  output logic [NW-1:0]         pixel_count
);

  localparam int BPP  = PIXEL_BITS / 8;
  localparam int NPIX = TOTAL_ROWS * TOTAL_COLS;
  localparam int BIW  = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [31:0]             pend_base_q, pend_base_d;
  logic                    start_pend_q, start_pend_d;
  logic [31:0]             addr_q, addr_d;
  logic [PIXEL_BITS-1:0]   color_q, color_d;
  logic [BIW-1:0]          byte_idx_q, byte_idx_d;
  logic [NW-1:0]           count_q, count_d;
  logic                    frame_done_q, frame_done_d;

  logic                    in_range;
  logic [31:0]             pix_offset;
  logic [PIXEL_BITS-1:0]   color_shift;

  // Bounds check and linear byte offset of the incoming pixel; all math is
  // done in 32 bits so the address wraps modulo 2^32.
  assign in_range   = (32'(in_row) < 32'(TOTAL_ROWS)) && (32'(in_col) < 32'(TOTAL_COLS));
  assign pix_offset = (32'(in_row) * 32'(TOTAL_COLS) + 32'(in_col)) * 32'(BPP);

  // Select the current byte of the latched colour (byte 0 = least significant).
  assign color_shift = color_q >> {byte_idx_q, 3'b000};

  assign frame_done  = frame_done_q;
  assign pixel_count = count_q;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      pend_base_q  <= '0;
      start_pend_q <= 1'b0;
      addr_q       <= '0;
      color_q      <= '0;
      byte_idx_q   <= '0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      pend_base_q  <= pend_base_d;
      start_pend_q <= start_pend_d;
      addr_q       <= addr_d;
      color_q      <= color_d;
      byte_idx_q   <= byte_idx_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    pend_base_d  = pend_base_q;
    start_pend_d = start_pend_q;
    addr_d       = addr_q;
    color_d      = color_q;
    byte_idx_d   = byte_idx_q;
    count_d      = count_q;
    frame_done_d = 1'b0;

    in_ready     = 1'b0;
    m1_write     = 1'b0;
    m1_address   = '0;
    m1_writedata = '0;
    busy         = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = !start && !start_pend_q;
        // A start always wins over an incoming pixel in the same cycle.
        if (start) begin
          base_d       = pixel_buffer;
          count_d      = '0;
          start_pend_d = 1'b0;
        end else if (start_pend_q) begin
          base_d       = pend_base_q;
          count_d      = '0;
          start_pend_d = 1'b0;
        end else if (in_valid && in_range) begin
          addr_d     = base_q + pix_offset;
          color_d    = in_color;
          byte_idx_d = '0;
          state_d    = S_WRITE;
        end
        // Out-of-range pixels are consumed and silently dropped.
      end

      S_WRITE: begin
        busy         = 1'b1;
        m1_write     = 1'b1;
        m1_address   = addr_q + 32'(byte_idx_q);
        m1_writedata = color_shift[7:0];

        // A start arriving mid-pixel is deferred; the transfer is never cut short.
        // The base seen at the first start is kept; repeats are ignored.
        if (start && !start_pend_q) begin
          start_pend_d = 1'b1;
          pend_base_d  = pixel_buffer;
        end

        if (!m1_waitrequest) begin
          if (byte_idx_q == BIW'(BPP - 1)) begin
            state_d = S_IDLE;
            if (count_q == NW'(NPIX - 1)) begin
              count_d      = '0;
              frame_done_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer. Three instances share one stimulus bus:
// A uses the default 192x256 frame, B a 2x2 frame (frame_done wrap),
// C a 3x3 frame (column out-of-range is representable there). The select
// variable routes in_valid/start to one instance and muxes its outputs.
module tb_pixel_writer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] pixel_buffer;
  logic        in_valid;
  logic [7:0]  in_row;
  logic [7:0]  in_col;
  logic [15:0] in_color;
  logic        waitreq;
  int          sel;

  int n_cmp;
  int n_err;

  // Instance A outputs
  logic        rdy_a, wr_a, busy_a, fd_a;
  logic [31:0] addr_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  // Instance B outputs
  logic        rdy_b, wr_b, busy_b, fd_b;
  logic [31:0] addr_b;
  logic [7:0]  data_b;
  logic [2:0]  cnt_b;
  // Instance C outputs
  logic        rdy_c, wr_c, busy_c, fd_c;
  logic [31:0] addr_c;
  logic [7:0]  data_c;
  logic [3:0]  cnt_c;

  // Muxed view of the selected instance
  logic        o_rdy, o_wr, o_busy, o_fd;
  logic [31:0] o_addr, o_cnt;
  logic [7:0]  o_data;

  pixel_writer u_a (
    .clock          (clock),
    .reset          (reset),
    .start          (start && sel == 0),
    .pixel_buffer   (pixel_buffer),
    .in_valid       (in_valid && sel == 0),
    .in_ready       (rdy_a),
    .in_row         (in_row),
    .in_col         (in_col),
    .in_color       (in_color),
    .m1_address     (addr_a),
    .m1_writedata   (data_a),
    .m1_write       (wr_a),
    .m1_waitrequest (waitreq),
    .busy           (busy_a),
    .frame_done     (fd_a),
    .pixel_count    (cnt_a)
  );

  pixel_writer #(.TOTAL_ROWS(2), .TOTAL_COLS(2), .PIXEL_BITS(16)) u_b (
    .clock          (clock),
    .reset          (reset),
    .start          (start && sel == 1),
    .pixel_buffer   (pixel_buffer),
    .in_valid       (in_valid && sel == 1),
    .in_ready       (rdy_b),
    .in_row         (in_row[0:0]),
    .in_col         (in_col[0:0]),
    .in_color       (in_color),
    .m1_address     (addr_b),
    .m1_writedata   (data_b),
    .m1_write       (wr_b),
    .m1_waitrequest (waitreq),
    .busy           (busy_b),
    .frame_done     (fd_b),
    .pixel_count    (cnt_b)
  );

  pixel_writer #(.TOTAL_ROWS(3), .TOTAL_COLS(3), .PIXEL_BITS(16)) u_c (
    .clock          (clock),
    .reset          (reset),
    .start          (start && sel == 2),
    .pixel_buffer   (pixel_buffer),
    .in_valid       (in_valid && sel == 2),
    .in_ready       (rdy_c),
    .in_row         (in_row[1:0]),
    .in_col         (in_col[1:0]),
    .in_color       (in_color),
    .m1_address     (addr_c),
    .m1_writedata   (data_c),
    .m1_write       (wr_c),
    .m1_waitrequest (waitreq),
    .busy           (busy_c),
    .frame_done     (fd_c),
    .pixel_count    (cnt_c)
  );

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    o_rdy = rdy_a; o_wr = wr_a; o_busy = busy_a; o_fd = fd_a;
    o_addr = addr_a; o_data = data_a; o_cnt = 32'(cnt_a);
    case (sel)
      1: begin
        o_rdy = rdy_b; o_wr = wr_b; o_busy = busy_b; o_fd = fd_b;
        o_addr = addr_b; o_data = data_b; o_cnt = 32'(cnt_b);
      end
      2: begin
        o_rdy = rdy_c; o_wr = wr_c; o_busy = busy_c; o_fd = fd_c;
        o_addr = addr_c; o_data = data_c; o_cnt = 32'(cnt_c);
      end
      default: ;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one pixel for a single cycle; in_ready must be high when offered.
  task automatic send(input logic [7:0] r, input logic [7:0] c, input logic [15:0] col);
    in_row   = r;
    in_col   = c;
    in_color = col;
    in_valid = 1'b1;
    #1;
    chk("send_ready", 32'(o_rdy), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] t5_col [4];
  int          k, nw, nfd, last_wr;
  logic        acc;
  logic [15:0] cv;
  logic [7:0]  exp_b;

  initial begin
    n_cmp = 0; n_err = 0;
    sel = 0; reset = 1'b1; start = 1'b0; pixel_buffer = '0;
    in_valid = 1'b0; in_row = '0; in_col = '0; in_color = '0; waitreq = 1'b0;

    // T1: reset held two cycles
    tick(); tick();
    chk("t1_write", 32'(o_wr), 32'd0);
    chk("t1_busy",  32'(o_busy), 32'd0);
    chk("t1_fd",    32'(o_fd), 32'd0);
    chk("t1_cnt",   o_cnt, 32'd0);
    chk("t1_ready", 32'(o_rdy), 32'd1);
    reset = 1'b0;

    // T2: start then one pixel (2,3) colour 0xABCD
    pixel_buffer = 32'h0800_0000;
    start = 1'b1;
    #1;
    chk("t2_start_ready", 32'(o_rdy), 32'd0);
    tick();
    start = 1'b0;
    send(8'd2, 8'd3, 16'hABCD);
    chk("t2_b0_wr",   32'(o_wr), 32'd1);
    chk("t2_b0_addr", o_addr, 32'h0800_0406);
    chk("t2_b0_data", 32'(o_data), 32'h0000_00CD);
    chk("t2_busy",    32'(o_busy), 32'd1);
    chk("t2_ready",   32'(o_rdy), 32'd0);
    tick();
    chk("t2_b1_addr", o_addr, 32'h0800_0407);
    chk("t2_b1_data", 32'(o_data), 32'h0000_00AB);
    tick();
    chk("t2_done_wr",  32'(o_wr), 32'd0);
    chk("t2_cnt",      o_cnt, 32'd1);
    chk("t2_ready_bk", 32'(o_rdy), 32'd1);

    // T3: same pixel, first byte stalled 3 cycles
    waitreq = 1'b1;
    send(8'd2, 8'd3, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_addr", o_addr, 32'h0800_0406);
      chk("t3_stall_data", 32'(o_data), 32'h0000_00CD);
      chk("t3_stall_wr",   32'(o_wr), 32'd1);
      chk("t3_stall_rdy",  32'(o_rdy), 32'd0);
      tick();
    end
    waitreq = 1'b0;
    chk("t3_b0_addr", o_addr, 32'h0800_0406);
    chk("t3_b0_data", 32'(o_data), 32'h0000_00CD);
    tick();
    chk("t3_b1_addr", o_addr, 32'h0800_0407);
    chk("t3_b1_data", 32'(o_data), 32'h0000_00AB);
    tick();
    chk("t3_wr_off", 32'(o_wr), 32'd0);
    chk("t3_cnt",    o_cnt, 32'd2);

    // T4: out-of-range row on A; out-of-range col/row and one valid pixel on C (3x3)
    send(8'd192, 8'd0, 16'h1111);
    chk("t4a_wr",   32'(o_wr), 32'd0);
    chk("t4a_busy", 32'(o_busy), 32'd0);
    chk("t4a_cnt",  o_cnt, 32'd2);
    chk("t4a_rdy",  32'(o_rdy), 32'd1);
    sel = 2;
    send(8'd0, 8'd3, 16'h1234);
    chk("t4c_col_wr",  32'(o_wr), 32'd0);
    chk("t4c_col_cnt", o_cnt, 32'd0);
    send(8'd3, 8'd0, 16'h1234);
    chk("t4c_row_wr",  32'(o_wr), 32'd0);
    chk("t4c_row_cnt", o_cnt, 32'd0);
    send(8'd1, 8'd2, 16'h5678);
    chk("t4c_b0_addr", o_addr, 32'h0000_000A);
    chk("t4c_b0_data", 32'(o_data), 32'h0000_0078);
    tick();
    chk("t4c_b1_addr", o_addr, 32'h0000_000B);
    chk("t4c_b1_data", 32'(o_data), 32'h0000_0056);
    tick();
    chk("t4c_cnt", o_cnt, 32'd1);

    // T5: 2x2 frame, four pixels back-to-back on B
    sel = 1;
    t5_col[0] = 16'hA050; t5_col[1] = 16'hA151;
    t5_col[2] = 16'hA252; t5_col[3] = 16'hA353;
    k = 0; nw = 0; nfd = 0; last_wr = -10;
    for (int cyc = 0; cyc < 16; cyc++) begin
      in_valid = (k < 4);
      in_row   = 8'(k >> 1);
      in_col   = 8'(k & 1);
      in_color = t5_col[k & 3];
      #1;
      if (o_fd) begin
        nfd++;
        chk("t5_fd_cnt", o_cnt, 32'd0);
        chk("t5_fd_timing", 32'(cyc), 32'(last_wr + 1));
      end
      if (o_wr) begin
        cv    = t5_col[(nw / 2) & 3];
        exp_b = (nw % 2 == 1) ? cv[15:8] : cv[7:0];
        chk("t5_addr", o_addr, 32'(nw));
        chk("t5_data", 32'(o_data), 32'(exp_b));
        last_wr = cyc;
        nw++;
      end
      acc = o_rdy && in_valid;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("t5_nwrites", 32'(nw), 32'd8);
    chk("t5_nfd", 32'(nfd), 32'd1);
    chk("t5_cnt_end", o_cnt, 32'd0);

    // T6: start during the first byte of a pixel on A
    sel = 0;
    pixel_buffer = 32'h1000_0000;
    send(8'd0, 8'd1, 16'h2211);
    start = 1'b1;
    chk("t6_old_b0_addr", o_addr, 32'h0800_0002);
    chk("t6_old_b0_data", 32'(o_data), 32'h0000_0011);
    tick();
    start = 1'b0;
    chk("t6_old_b1_addr", o_addr, 32'h0800_0003);
    chk("t6_old_b1_data", 32'(o_data), 32'h0000_0022);
    tick();
    in_row = 8'd0; in_col = 8'd0; in_color = 16'h4433; in_valid = 1'b1;
    #1;
    chk("t6_pend_rdy", 32'(o_rdy), 32'd0);
    chk("t6_pend_cnt", o_cnt, 32'd3);
    tick();
    chk("t6_noaccept_wr", 32'(o_wr), 32'd0);
    chk("t6_cleared_cnt", o_cnt, 32'd0);
    chk("t6_rdy_back", 32'(o_rdy), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t6_new_b0_addr", o_addr, 32'h1000_0000);
    chk("t6_new_b0_data", 32'(o_data), 32'h0000_0033);
    tick();
    chk("t6_new_b1_addr", o_addr, 32'h1000_0001);
    chk("t6_new_b1_data", 32'(o_data), 32'h0000_0044);
    tick();
    chk("t6_cnt", o_cnt, 32'd1);

    // Reset in the middle of a pixel drops it
    send(8'd5, 8'd5, 16'hBEEF);
    chk("rst_pre_wr", 32'(o_wr), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wr",   32'(o_wr), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cnt",  o_cnt, 32'd0);
    chk("rst_rdy",  32'(o_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
